// File: rtl/spi_shift_engine_if.sv
// Byte-stream and SPI pin bundle for spi_shift_engine.
// The slave modport is the engine's view; master is the upstream/flash side.
interface spi_shift_engine_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;

  modport slave (
    input  tx_valid, tx_data, tx_last, spi_miso,
    output tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
  );

  modport master (
    output tx_valid, tx_data, tx_last, spi_miso,
    input  tx_ready, rx_valid, rx_data, busy, spi_sck, spi_cs_n, spi_mosi
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte shift engine with chip-select framing for a serial flash.
// Receive capture is built only when macro SPI_SHIFT_RX_EN is defined.
module spi_shift_engine #(
  parameter int DIV_HALF = 2,
  parameter int CS_GAP   = 2
) (
  input  logic              p_clk,
  input  logic              p_reset_n,
  spi_shift_engine_if.slave bus
);

  localparam logic [7:0] HALF_RELOAD = 8'(DIV_HALF - 1);
  localparam logic [7:0] GAP_RELOAD  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [7:0] r_cnt;
  logic [2:0] r_bitCnt;
  logic [7:0] r_txShift;
  logic       r_last;
  logic       r_sck;
  logic       r_csN;
  logic       r_mosi;
  logic       r_ready;
  logic       w_accept;
  logic       w_cntZero;
  logic       w_byteDone;
  logic       w_sampleEdge;

  assign w_accept   = bus.tx_valid & r_ready;
  assign w_cntZero  = (r_cnt == 8'd0);
  assign w_byteDone = (r_state == SHIFT) && w_cntZero && !r_sck && (r_bitCnt == 3'd0);
  // Edges that raise SCK: end of SETUP, end of a low half (not the last), or a WAIT accept.
  assign w_sampleEdge = ((r_state == SETUP) && w_cntZero) ||
                        ((r_state == SHIFT) && w_cntZero && !r_sck && (r_bitCnt != 3'd0)) ||
                        ((r_state == WAIT) && w_accept);

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) r_state <= IDLE;
    else            r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_nextState = SETUP;
      SETUP:   if (w_cntZero)  w_nextState = SHIFT;
      SHIFT:   if (w_byteDone) w_nextState = r_last ? HOLD : WAIT;
      WAIT:    if (w_accept)   w_nextState = SHIFT;
      HOLD:    if (w_cntZero)  w_nextState = GAP;
      GAP:     if (w_cntZero)  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Ready is registered so it stays low through reset and rises one clock after release.
  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_ready   <= 1'b0;
      r_cnt     <= 8'd0;
      r_bitCnt  <= 3'd0;
      r_txShift <= 8'd0;
      r_last    <= 1'b0;
      r_sck     <= 1'b0;
      r_csN     <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_ready <= (w_nextState == IDLE) || (w_nextState == WAIT);
      if (w_accept) begin
        r_txShift <= bus.tx_data;
        r_last    <= bus.tx_last;
        r_mosi    <= bus.tx_data[7];
        r_bitCnt  <= 3'd7;
        r_cnt     <= HALF_RELOAD;
        r_csN     <= 1'b0;
        if (r_state == WAIT) r_sck <= 1'b1;
      end else begin
        case (r_state)
          SETUP: begin
            if (w_cntZero) begin
              r_sck <= 1'b1;
              r_cnt <= HALF_RELOAD;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          SHIFT: begin
            if (!w_cntZero) begin
              r_cnt <= r_cnt - 8'd1;
            end else if (r_sck) begin
              r_sck <= 1'b0;
              r_cnt <= HALF_RELOAD;
              if (r_bitCnt != 3'd0) begin
                r_mosi    <= r_txShift[6];
                r_txShift <= {r_txShift[6:0], 1'b0};
              end
            end else begin
              r_cnt <= HALF_RELOAD;
              if (r_bitCnt != 3'd0) begin
                r_bitCnt <= r_bitCnt - 3'd1;
                r_sck    <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (w_cntZero) begin
              r_csN  <= 1'b1;
              r_mosi <= 1'b0;
              r_cnt  <= GAP_RELOAD;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          GAP: begin
            if (!w_cntZero) r_cnt <= r_cnt - 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_SHIFT_RX_EN
  logic [7:0] r_rxShift;
  logic [7:0] r_rxData;
  logic       r_rxValid;

  always_ff @(posedge p_clk or negedge p_reset_n) begin
    if (!p_reset_n) begin
      r_rxShift <= 8'd0;
      r_rxData  <= 8'd0;
      r_rxValid <= 1'b0;
    end else begin
      r_rxValid <= w_byteDone;
      if (w_sampleEdge) r_rxShift <= {r_rxShift[6:0], bus.spi_miso};
      if (w_byteDone)   r_rxData  <= r_rxShift;
    end
  end

  assign bus.rx_valid = r_rxValid;
  assign bus.rx_data  = r_rxData;
`else
  assign bus.rx_valid = 1'b0;
  assign bus.rx_data  = 8'd0;
`endif

  assign bus.tx_ready = r_ready;
  assign bus.busy     = (r_state != IDLE);
  assign bus.spi_sck  = r_sck;
  assign bus.spi_cs_n = r_csN;
  assign bus.spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: one DUT at DIV_HALF=2 with a MISO model,
// one at DIV_HALF=1; waveforms are recorded per cycle and checked against hand values.
module tb_spi_shift_engine;

`ifdef SPI_SHIFT_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  logic p_clk = 1'b0;
  logic rstN;

  spi_shift_engine_if bus0();
  spi_shift_engine_if bus1();

  spi_shift_engine #(.DIV_HALF(2), .CS_GAP(2)) dut0 (.p_clk(p_clk), .p_reset_n(rstN), .bus(bus0.slave));
  spi_shift_engine #(.DIV_HALF(1), .CS_GAP(2)) dut1 (.p_clk(p_clk), .p_reset_n(rstN), .bus(bus1.slave));

  always #5 p_clk = ~p_clk;

  // Flash model: presents the next MISO bit after each SCK fall, restarts when CS rises.
  logic [31:0] misoWord = 32'h0;
  int          misoIdx  = 0;
  always @(negedge bus0.spi_sck or posedge bus0.spi_cs_n) begin
    if (bus0.spi_cs_n === 1'b1)      misoIdx = 0;
    else if (bus0.spi_cs_n === 1'b0) misoIdx = misoIdx + 1;
  end
  assign bus0.spi_miso = (misoIdx < 32) ? misoWord[31 - misoIdx] : 1'b0;
  assign bus1.spi_miso = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic       recCs[0:199], recSck[0:199], recMosi[0:199], recRxv[0:199], recReady[0:199], recBusy[0:199];
  logic [7:0] recRxd[0:199];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sampleCycle(input int sel, input int c);
    if (sel == 0) begin
      recCs[c] = bus0.spi_cs_n; recSck[c] = bus0.spi_sck; recMosi[c] = bus0.spi_mosi;
      recRxv[c] = bus0.rx_valid; recRxd[c] = bus0.rx_data; recReady[c] = bus0.tx_ready; recBusy[c] = bus0.busy;
    end else begin
      recCs[c] = bus1.spi_cs_n; recSck[c] = bus1.spi_sck; recMosi[c] = bus1.spi_mosi;
      recRxv[c] = bus1.rx_valid; recRxd[c] = bus1.rx_data; recReady[c] = bus1.tx_ready; recBusy[c] = bus1.busy;
    end
  endtask

  task automatic driveIn(input int sel, input logic v, input logic [7:0] d, input logic l);
    if (sel == 0) begin bus0.tx_valid = v; bus0.tx_data = d; bus0.tx_last = l; end
    else          begin bus1.tx_valid = v; bus1.tx_data = d; bus1.tx_last = l; end
  endtask

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? bus0.tx_ready : bus1.tx_ready;
  endfunction

  // Cycle 0 is the cycle in which tx_valid meets tx_ready; inputs are scrambled from cycle 1.
  task automatic applyStimulus(input int sel, input logic [7:0] d, input logic l, input int ncyc);
    int guard = 0;
    while (readyOf(sel) !== 1'b1 && guard < 200) begin
      @(negedge p_clk);
      guard++;
    end
    checkOutput("readyWait", readyOf(sel), 1);
    for (int c = 0; c < ncyc; c++) begin
      sampleCycle(sel, c);
      if (c == 0)      driveIn(sel, 1'b1, d, l);
      else if (c == 1) driveIn(sel, 1'b0, ~d, ~l);
      @(negedge p_clk);
    end
  endtask

  function automatic bit isRise(input int c);
    return (recSck[c] === 1'b1) && (c == 0 || recSck[c-1] === 1'b0);
  endfunction

  function automatic int riseCount(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (isRise(c)) k++;
    return k;
  endfunction

  function automatic int riseErrors(input int n, input int first, input int period);
    int k = 0;
    int err = 0;
    for (int c = 0; c < n; c++) begin
      if (isRise(c)) begin
        if (c != first + k * period) err++;
        k++;
      end
    end
    return err;
  endfunction

  function automatic logic [7:0] mosiBits(input int n);
    logic [7:0] b = 8'h0;
    int k = 0;
    for (int c = 0; c < n; c++) begin
      if (isRise(c) && k < 8) begin
        b = {b[6:0], recMosi[c]};
        k++;
      end
    end
    return b;
  endfunction

  function automatic int firstRx(input int n);
    for (int c = 0; c < n; c++) if (recRxv[c] === 1'b1) return c;
    return -1;
  endfunction

  function automatic int countOnes(input int sig, input int a, input int b, input logic val);
    int k = 0;
    for (int c = a; c <= b; c++) begin
      case (sig)
        0: if (recCs[c] === val) k++;
        1: if (recSck[c] === val) k++;
        2: if (recRxv[c] === val) k++;
        default: if (recReady[c] === val) k++;
      endcase
    end
    return k;
  endfunction

  function automatic logic [7:0] rxAt(input int c);
    return (c >= 0) ? recRxd[c] : 8'h00;
  endfunction

  logic [7:0] readBytes[0:3];
  logic [7:0] readMiso[0:3];

  initial begin
    int idx;
    int rxSeen;
    logic curValid;
    logic prevReady;

    readBytes[0] = 8'h03; readBytes[1] = 8'h12; readBytes[2] = 8'h34; readBytes[3] = 8'h56;
    readMiso[0]  = 8'hDE; readMiso[1]  = 8'hAD; readMiso[2]  = 8'hBE; readMiso[3]  = 8'hEF;

    rstN = 1'b0;
    driveIn(0, 1'b0, 8'h00, 1'b0);
    driveIn(1, 1'b0, 8'h00, 1'b0);
    $display("[TB] reset state");
    @(negedge p_clk);
    @(negedge p_clk);
    checkOutput("rstCsN",   bus0.spi_cs_n, 1);
    checkOutput("rstSck",   bus0.spi_sck,  0);
    checkOutput("rstMosi",  bus0.spi_mosi, 0);
    checkOutput("rstReady", bus0.tx_ready, 0);
    checkOutput("rstRxv",   bus0.rx_valid, 0);
    checkOutput("rstRxd",   bus0.rx_data,  0);
    checkOutput("rstBusy",  bus0.busy,     0);
    rstN = 1'b1;
    @(negedge p_clk);
    checkOutput("readyAfterRst", bus0.tx_ready, 1);

    $display("[TB] single byte 0xA5, last");
    misoWord = {8'h3C, 24'h0};
    applyStimulus(0, 8'hA5, 1'b1, 42);
    checkOutput("t1CsBefore", recCs[0], 1);
    checkOutput("t1CsLow",    countOnes(0, 1, 36, 1'b0), 36);
    checkOutput("t1CsAfter",  recCs[37], 1);
    checkOutput("t1Rises",    riseCount(42), 8);
    checkOutput("t1RisePos",  riseErrors(42, 3, 4), 0);
    checkOutput("t1Mosi",     mosiBits(42), 8'hA5);
    checkOutput("t1RxCycle",  firstRx(42), RX_ON ? 35 : -1);
    checkOutput("t1RxCount",  countOnes(2, 0, 41, 1'b1), RX_ON ? 1 : 0);
    checkOutput("t1RxData",   rxAt(firstRx(42)), RX_ON ? 8'h3C : 8'h00);
    checkOutput("t1Ready38",  recReady[38], 0);
    checkOutput("t1Ready39",  recReady[39], 1);
    checkOutput("t1Busy1",    recBusy[1], 1);
    checkOutput("t1Busy39",   recBusy[39], 0);

    $display("[TB] four-byte read, tx_valid held");
    misoWord = {readMiso[0], readMiso[1], readMiso[2], readMiso[3]};
    idx = 0;
    prevReady = 1'b0;
    curValid = 1'b1;
    for (int c = 0; c < 140; c++) begin
      sampleCycle(0, c);
      if (c > 0 && prevReady && curValid) idx++;
      curValid = (idx < 4);
      driveIn(0, curValid, (idx < 4) ? readBytes[idx] : 8'h00, idx == 3);
      prevReady = recReady[c];
      @(negedge p_clk);
    end
    checkOutput("t2Rises",    riseCount(140), 32);
    checkOutput("t2RxCount",  countOnes(2, 0, 139, 1'b1), RX_ON ? 4 : 0);
    checkOutput("t2CsLow",    countOnes(0, 1, 135, 1'b0), 135);
    checkOutput("t2CsHigh",   recCs[136], 1);
    checkOutput("t2WaitReady", countOnes(3, 1, 134, 1'b1), 3);
    rxSeen = 0;
    for (int c = 0; c < 140; c++) begin
      if (recRxv[c] === 1'b1) begin
        checkOutput("t2RxByte", recRxd[c], readMiso[rxSeen & 3]);
        rxSeen++;
      end
    end

    $display("[TB] non-last byte then long pause");
    misoWord = {8'h96, 8'h69, 16'h0};
    applyStimulus(0, 8'h81, 1'b0, 36);
    checkOutput("t3Mosi1",   mosiBits(36), 8'h81);
    checkOutput("t3RxData1", rxAt(firstRx(36)), RX_ON ? 8'h96 : 8'h00);
    for (int c = 0; c < 50; c++) begin
      sampleCycle(0, c);
      @(negedge p_clk);
    end
    checkOutput("t3PauseCs",    countOnes(0, 0, 49, 1'b0), 50);
    checkOutput("t3PauseSck",   countOnes(1, 0, 49, 1'b0), 50);
    checkOutput("t3PauseReady", countOnes(3, 0, 49, 1'b1), 50);
    applyStimulus(0, 8'h42, 1'b1, 42);
    checkOutput("t3RisePos2", riseErrors(42, 1, 4), 0);
    checkOutput("t3Rises2",   riseCount(42), 8);
    checkOutput("t3Mosi2",    mosiBits(42), 8'h42);
    checkOutput("t3RxCycle2", firstRx(42), RX_ON ? 33 : -1);
    checkOutput("t3RxData2",  rxAt(firstRx(42)), RX_ON ? 8'h69 : 8'h00);
    checkOutput("t3CsEnd",    recCs[35], 1);

    $display("[TB] reset mid-byte");
    misoWord = {8'hA5, 24'h0};
    applyStimulus(0, 8'hC3, 1'b1, 15);
    #2 rstN = 1'b0;
    #1;
    checkOutput("t4AsyncCs",   bus0.spi_cs_n, 1);
    checkOutput("t4AsyncSck",  bus0.spi_sck,  0);
    checkOutput("t4AsyncBusy", bus0.busy,     0);
    @(negedge p_clk);
    @(negedge p_clk);
    rstN = 1'b1;
    for (int c = 0; c < 40; c++) begin
      sampleCycle(0, c);
      @(negedge p_clk);
    end
    checkOutput("t4NoRx",     countOnes(2, 0, 39, 1'b1), 0);
    checkOutput("t4CsIdle",   countOnes(0, 0, 39, 1'b1), 40);
    applyStimulus(0, 8'h3C, 1'b1, 42);
    checkOutput("t4Mosi",     mosiBits(42), 8'h3C);
    checkOutput("t4RxCycle",  firstRx(42), RX_ON ? 35 : -1);
    checkOutput("t4RxData",   rxAt(firstRx(42)), RX_ON ? 8'hA5 : 8'h00);

    $display("[TB] DIV_HALF=1, bytes 0xFF then 0x00");
    applyStimulus(1, 8'hFF, 1'b0, 20);
    checkOutput("t5Rises1",   riseCount(20), 8);
    checkOutput("t5RisePos1", riseErrors(20, 2, 2), 0);
    checkOutput("t5Mosi1",    mosiBits(20), 8'hFF);
    checkOutput("t5RxCycle1", firstRx(20), RX_ON ? 18 : -1);
    applyStimulus(1, 8'h00, 1'b1, 24);
    checkOutput("t5RisePos2", riseErrors(24, 1, 2), 0);
    checkOutput("t5Mosi2",    mosiBits(24), 8'h00);
    checkOutput("t5RxCycle2", firstRx(24), RX_ON ? 17 : -1);
    checkOutput("t5CsHold",   recCs[17], 0);
    checkOutput("t5CsEnd",    recCs[18], 1);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
